ifetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the mproc_mem datapath/decode.

---
 rtl/ifetch_if.sv | 42 ++++
 rtl/ifetch_unit.sv | 178 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
`timescale 1ns/1ps
// ifetch_if: bundles the instruction-memory read port, the redirect request
// and the {pc, instr} consumer handshake of the fetch stage.
// master = fetch unit side, slave = memory/consumer/branch side.
interface ifetch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_rd,
        output imem_addr,
        input  imem_data,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        output imem_data,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
// ifetch_unit: sequential PC generator reading a synchronous instruction
// memory, with a small prefetch FIFO feeding {pc, instr} to the decoder over
// valid/ready. A redirect flushes the FIFO and restarts fetch at redirect_pc.
// Issue is credit based (FIFO count + outstanding read < DEPTH), so the FIFO
// can never overflow.
// Optional feature: define IFETCH_PERF_CNT_EN to add the saturating
// perf_fetch / perf_stall counters.
module ifetch_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic       clk,
    input  logic       reset,
    ifetch_if.master   bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetch,
    output logic [15:0] perf_stall
`endif
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [DATA_W-1:0] r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W:0]    w_occupancy;
    logic              w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_out_valid;

    // Credits count both stored words and the read whose data arrives next cycle.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit    = (w_occupancy < DEPTH_L);
    // The read strobe is held low while reset is asserted so it shows its reset value.
    assign w_issue     = ~reset & (r_state == ST_RUN) & w_credit & ~bus.redirect;
    // A word returning in a redirect cycle belongs to the old path and is dropped.
    assign w_push      = r_inflight & ~bus.redirect;
    assign w_out_valid = (r_count != {CNT_W{1'b0}});
    assign w_pop       = w_out_valid & bus.out_ready;

    assign bus.imem_rd   = w_issue;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = r_fifo_instr[r_rd_ptr];
    assign bus.out_pc    = r_fifo_pc[r_rd_ptr];

    // Next fetch state: redirect always restarts RUN, otherwise stall on lack of credit.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_credit) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_credit) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC advance (modulo 2^ADDR_W) and tracking of the outstanding read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            if (bus.redirect) begin
                r_pc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_ONE;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    // FIFO storage: returned word is written at the tail together with its PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= {DATA_W{1'b0}};
                r_fifo_pc[i]    <= {ADDR_W{1'b0}};
            end
        end else if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.imem_data;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (bus.redirect) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Saturating counters of read cycles and of stalled/starved cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch <= 16'h0000;
            perf_stall <= 16'h0000;
        end else begin
            if (w_issue && (perf_fetch != 16'hFFFF)) begin
                perf_fetch <= perf_fetch + 16'h0001;
            end
            if (((r_state == ST_HOLD) || (!w_out_valid && bus.out_ready)) &&
                (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
// tb_ifetch_unit: directed scoreboard bench. Instance A (RESET_PC=0) covers
// free run, back-pressure, redirects and mid-run reset; instance B
// (RESET_PC=0xFE) covers PC wrap. Memory returns mem[a] = 0x100 + a.
module tb_ifetch_unit;
    localparam int DW = 16;
    localparam int AW = 8;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic reset_b;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    ifetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    ifetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_a, perf_stall_a, perf_fetch_b, perf_stall_b;
`endif

    ifetch_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .RESET_PC(8'h00)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
`ifdef IFETCH_PERF_CNT_EN
       ,.perf_fetch (perf_fetch_a)
       ,.perf_stall (perf_stall_a)
`endif
    );

    ifetch_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .RESET_PC(8'hFE)) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
`ifdef IFETCH_PERF_CNT_EN
       ,.perf_fetch (perf_fetch_b)
       ,.perf_stall (perf_stall_b)
`endif
    );

    // Synchronous instruction memories: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (reset) bus_a.imem_data <= 16'h0000;
        else if (bus_a.imem_rd) bus_a.imem_data <= 16'h0100 + {8'h00, bus_a.imem_addr};
        if (reset_b) bus_b.imem_data <= 16'h0000;
        else if (bus_b.imem_rd) bus_b.imem_data <= 16'h0100 + {8'h00, bus_b.imem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic exp_a(input logic [AW-1:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = 16'h0100 + {8'h00, pc};
        q_a.push_back(e);
    endtask

    task automatic exp_b(input logic [AW-1:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = 16'h0100 + {8'h00, pc};
        q_b.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at the start of a cycle; leaves the bench at the start of cycle 0 after release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_imem_rd", 32'(bus_a.imem_rd), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor A: every accepted head is compared with the scoreboard front.
    always @(negedge clk) begin
        if (!reset && bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) begin
                n_checks++;
                $display("FAIL a_extra_output: got pc 0x%0h expected no output", bus_a.out_pc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_out_pc", 32'(bus_a.out_pc), 32'(e.pc));
                chk("a_out_instr", 32'(bus_a.out_instr), 32'(e.instr));
            end
        end
    end

    // Monitor B: same for the wrap-around instance.
    always @(negedge clk) begin
        if (!reset_b && bus_b.out_valid && bus_b.out_ready) begin
            if (q_b.size() == 0) begin
                n_checks++;
                $display("FAIL b_extra_output: got pc 0x%0h expected no output", bus_b.out_pc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_out_pc", 32'(bus_b.out_pc), 32'(e.pc));
                chk("b_out_instr", 32'(bus_b.out_instr), 32'(e.instr));
            end
        end
    end

    initial begin
        int n_rd;
        logic [AW-1:0] ea;
        reset = 1'b1;
        reset_b = 1'b1;
        bus_a.redirect = 1'b0;
        bus_a.redirect_pc = 8'h00;
        bus_a.out_ready = 1'b1;
        bus_b.redirect = 1'b0;
        bus_b.redirect_pc = 8'h00;
        bus_b.out_ready = 1'b1;
        #1;
        chk("reset_imem_rd", 32'(bus_a.imem_rd), 32'd0);
        chk("reset_imem_addr", 32'(bus_a.imem_addr), 32'h00);
        chk("reset_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("reset_out_instr", 32'(bus_a.out_instr), 32'h0);
        chk("reset_out_pc", 32'(bus_a.out_pc), 32'h0);
        chk("reset_b_imem_addr", 32'(bus_b.imem_addr), 32'hFE);

        // Test 1 / 4: free run from reset; B wraps FE, FF, 00, 01.
        for (int p = 0; p < 6; p++) exp_a(8'(p));
        exp_b(8'hFE); exp_b(8'hFF); exp_b(8'h00); exp_b(8'h01);
        #11.5;
        reset = 1'b0;
        reset_b = 1'b0;
        for (int c = 1; c < 8; c++) begin
            next_cycle();
            if (c == 6) bus_b.out_ready = 1'b0;
            @(negedge clk);
            chk("t1_imem_rd", 32'(bus_a.imem_rd), 32'd1);
            chk("t1_imem_addr", 32'(bus_a.imem_addr), 32'(c));
            chk("t1_out_valid", 32'(bus_a.out_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c < 6) begin
                ea = 8'hFE + 8'(c);
                chk("t4_imem_rd", 32'(bus_b.imem_rd), 32'd1);
                chk("t4_imem_addr", 32'(bus_b.imem_addr), 32'(ea));
            end
        end
        next_cycle();
        bus_a.out_ready = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        chk("t1_hold_rd", 32'(bus_a.imem_rd), 32'd0);
        chk("t1_hold_head_pc", 32'(bus_a.out_pc), 32'h06);
        chk("t1_drain", 32'(q_a.size()), 32'd0);
        chk("t4_drain", 32'(q_b.size()), 32'd0);
        next_cycle();

        // Test 2: back-pressure, exactly DEPTH issues then HOLD, release in order.
        do_reset();
        bus_a.out_ready = 1'b0;
        for (int p = 0; p < 6; p++) exp_a(8'(p));
        n_rd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_a.imem_rd) begin
                chk("t2_issue_addr", 32'(bus_a.imem_addr), 32'(n_rd));
                n_rd++;
            end
            if (c == 9) begin
                chk("t2_full_valid", 32'(bus_a.out_valid), 32'd1);
                chk("t2_full_head_pc", 32'(bus_a.out_pc), 32'h00);
            end
            next_cycle();
        end
        chk("t2_issue_count", 32'(n_rd), 32'd4);
        bus_a.out_ready = 1'b1;
        repeat (6) next_cycle();
        bus_a.out_ready = 1'b0;
        chk("t2_drain", 32'(q_a.size()), 32'd0);

        // Test 3: redirect with one read in flight and two words queued.
        do_reset();
        bus_a.out_ready = 1'b0;
        exp_a(8'h00);
        exp_a(8'h40); exp_a(8'h41); exp_a(8'h42);
        exp_a(8'h90); exp_a(8'h91); exp_a(8'h92);
        repeat (3) next_cycle();
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 8'h40;
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_rd_in_redirect", 32'(bus_a.imem_rd), 32'd0);
        next_cycle();
        bus_a.redirect = 1'b0;
        @(negedge clk);
        chk("t3_new_rd", 32'(bus_a.imem_rd), 32'd1);
        chk("t3_new_addr", 32'(bus_a.imem_addr), 32'h40);
        chk("t3_flush_valid", 32'(bus_a.out_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t3_addr_next", 32'(bus_a.imem_addr), 32'h41);
        chk("t3_valid_bubble", 32'(bus_a.out_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t3_first_valid", 32'(bus_a.out_valid), 32'd1);
        repeat (3) next_cycle();
        bus_a.out_ready = 1'b0;
        next_cycle();
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 8'h80;
        next_cycle();
        bus_a.redirect_pc = 8'h90;
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        chk("t3b_valid_after_flush", 32'(bus_a.out_valid), 32'd0);
        chk("t3b_rd_in_redirect", 32'(bus_a.imem_rd), 32'd0);
        next_cycle();
        bus_a.redirect = 1'b0;
        @(negedge clk);
        chk("t3b_last_wins_addr", 32'(bus_a.imem_addr), 32'h90);
        chk("t3b_last_wins_rd", 32'(bus_a.imem_rd), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("t3b_valid_bubble", 32'(bus_a.out_valid), 32'd0);
        next_cycle();
        repeat (3) next_cycle();
        bus_a.out_ready = 1'b0;
        chk("t3_drain", 32'(q_a.size()), 32'd0);

        // Test 5: reset with three words queued; only fresh words afterwards.
        do_reset();
        bus_a.out_ready = 1'b0;
        repeat (4) next_cycle();
        for (int p = 0; p < 4; p++) exp_a(8'(p));
        do_reset();
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_refetch_addr", 32'(bus_a.imem_addr), 32'h00);
        chk("t5_refetch_rd", 32'(bus_a.imem_rd), 32'd1);
        repeat (6) next_cycle();
        bus_a.out_ready = 1'b0;
        chk("t5_drain", 32'(q_a.size()), 32'd0);

        // Test 6: 20 cycles of free run from reset.
        do_reset();
        bus_a.out_ready = 1'b1;
        for (int p = 0; p < 18; p++) exp_a(8'(p));
        repeat (20) next_cycle();
        bus_a.out_ready = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
        @(negedge clk);
        chk("t6_perf_fetch", 32'(perf_fetch_a), 32'd20);
        chk("t6_perf_stall", 32'(perf_stall_a), 32'd2);
`endif
        repeat (2) next_cycle();
        chk("t6_drain", 32'(q_a.size()), 32'd0);
        chk("final_b_drain", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
